calculator_bcd: RTL and testbench

//  Parametrised successor of the 4-bit switch calculator. Adds two WIDTH-bit switch operands, subtracts them

---
 rtl/calculator_bcd.sv | 254 +++++++++++++++++++++++++
 tb/tb_calculator_bcd.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calculator_bcd.sv
// Switch calculator: add, subtract either way or rotate two WIDTH-bit operands, convert the signed
// result to BCD with a sequential double-dabble engine, and scan it onto a multiplexed 7-seg display.
module calculator_bcd #(
    parameter int WIDTH   = 4,
    parameter int DIGITS  = 4,
    parameter int REFRESH = 16384
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [3:0]           button,
    input  logic [WIDTH-1:0]     switch_x,
    input  logic [WIDTH-1:0]     switch_y,
    output logic [2*WIDTH-1:0]   led,
    output logic                 busy,
    output logic [7:0]           cathode,
    output logic [DIGITS-1:0]    anode
);

    localparam int RW   = WIDTH + 2;
    localparam int MW   = RW - 1;
    localparam int NBCD = (MW * 3) / 10 + 1;
    localparam int SW   = 4 * NBCD + MW;
    localparam int CCW  = $clog2(MW + 1);
    localparam int CNTW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [7:0] GLYPH_MINUS = 8'b11111101;
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;

    typedef enum logic {S_IDLE, S_CONV} state_t;

    function automatic logic [7:0] seg_glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = 8'b00000011;
            4'd1:    g = 8'b10011111;
            4'd2:    g = 8'b00100101;
            4'd3:    g = 8'b00001101;
            4'd4:    g = 8'b10011001;
            4'd5:    g = 8'b01001001;
            4'd6:    g = 8'b01000001;
            4'd7:    g = 8'b00011111;
            4'd8:    g = 8'b00000001;
            4'd9:    g = 8'b00001001;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_conv_done;

    logic [3:0]         r_btn_s1, r_btn_s2, r_btn_prev;
    logic [3:0]         w_rise;
    logic               w_onehot;

    logic [2*WIDTH-1:0] r_led;
    logic [SW-1:0]      r_shift;
    logic [SW-1:0]      w_adj;
    logic [SW-1:0]      w_step;
    logic [CCW-1:0]     r_conv_cnt;
    logic               r_pend_neg;
    logic               r_pend_bin;
    logic [WIDTH-1:0]   r_pend_bits;

    logic [4*NBCD-1:0]  r_disp_bcd;
    logic               r_disp_neg;
    logic               r_disp_bin;
    logic [WIDTH-1:0]   r_disp_bits;

    logic [RW-1:0]      w_x_ext, w_y_ext, w_result;
    logic [WIDTH-1:0]   w_rot_amt;
    logic [2*WIDTH-1:0] w_rot_full;
    logic [MW-1:0]      w_mag;

    logic [CNTW-1:0]    r_refresh;
    logic [IDXW-1:0]    r_idx;
    logic [DIGITS-1:0]  r_anode;
    logic [7:0]         r_cathode;
    logic [8*DIGITS-1:0] w_glyph_flat;
    int                 w_ndig;
    int                 w_nsig;
    logic               w_ovf;

    // Edge detect after the synchroniser; only a lone rising bit with nothing else held counts.
    assign w_rise   = r_btn_s2 & ~r_btn_prev;
    assign w_onehot = (w_rise != 4'd0) && ((w_rise & (w_rise - 4'd1)) == 4'd0);

    assign w_x_ext    = {2'b00, switch_x};
    assign w_y_ext    = {2'b00, switch_y};
    assign w_rot_amt  = WIDTH'(switch_y % WIDTH);
    assign w_rot_full = {switch_x, switch_x} >> w_rot_amt;

    always_comb begin
        w_result = '0;
        if (w_rise[0])
            w_result = w_x_ext + w_y_ext;
        else if (w_rise[1])
            w_result = w_x_ext - w_y_ext;
        else if (w_rise[2])
            w_result = w_y_ext - w_x_ext;
        else if (w_rise[3])
            w_result = {2'b00, w_rot_full[WIDTH-1:0]};
    end

    assign w_mag = w_result[RW-1] ? (~w_result[MW-1:0] + MW'(1)) : w_result[MW-1:0];

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_conv_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_onehot && (r_btn_s2 == w_rise)) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CONV;
                end
            end
            S_CONV: begin
                if (r_conv_cnt == CCW'(MW - 1)) begin
                    w_conv_done  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Double-dabble step: bias every BCD nibble >= 5 by 3, then shift the whole register left.
    assign w_adj[MW-1:0] = r_shift[MW-1:0];
    generate
        for (genvar gi = 0; gi < NBCD; gi++) begin : g_dabble
            assign w_adj[MW+4*gi +: 4] = (r_shift[MW+4*gi +: 4] >= 4'd5)
                                       ? r_shift[MW+4*gi +: 4] + 4'd3
                                       : r_shift[MW+4*gi +: 4];
        end
    endgenerate
    assign w_step = w_adj << 1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_btn_s1    <= '0;
            r_btn_s2    <= '0;
            r_btn_prev  <= '0;
            r_led       <= '0;
            r_shift     <= '0;
            r_conv_cnt  <= '0;
            r_pend_neg  <= 1'b0;
            r_pend_bin  <= 1'b0;
            r_pend_bits <= '0;
            r_disp_bcd  <= '0;
            r_disp_neg  <= 1'b0;
            r_disp_bin  <= 1'b0;
            r_disp_bits <= '0;
        end else begin
            r_btn_s1   <= button;
            r_btn_s2   <= r_btn_s1;
            r_btn_prev <= r_btn_s2;
            if (w_accept) begin
                r_led       <= {switch_x, switch_y};
                r_shift     <= {{(4*NBCD){1'b0}}, w_mag};
                r_conv_cnt  <= '0;
                r_pend_neg  <= w_result[RW-1];
                r_pend_bin  <= w_rise[3];
                r_pend_bits <= w_result[WIDTH-1:0];
            end else if (r_state == S_CONV) begin
                r_shift    <= w_step;
                r_conv_cnt <= r_conv_cnt + CCW'(1);
                // Whole display image swaps in one edge so a half-converted value is never visible.
                if (w_conv_done) begin
                    r_disp_bcd  <= w_step[SW-1 -: 4*NBCD];
                    r_disp_neg  <= r_pend_neg;
                    r_disp_bin  <= r_pend_bin;
                    r_disp_bits <= r_pend_bits;
                end
            end
        end
    end

    always_comb begin
        w_ndig = 1;
        for (int k = 1; k < NBCD; k++) begin
            if (r_disp_bcd[4*k +: 4] != 4'd0)
                w_ndig = k + 1;
        end
        w_nsig = w_ndig + (r_disp_neg ? 1 : 0);
        w_ovf  = (w_nsig > DIGITS);
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] w_nib;
            logic       w_bit;
            logic [7:0] w_g;
            if (gi < NBCD) begin : g_nib
                assign w_nib = r_disp_bcd[4*gi +: 4];
            end else begin : g_nonib
                assign w_nib = 4'd0;
            end
            if (gi < WIDTH) begin : g_bit
                assign w_bit = r_disp_bits[gi];
            end else begin : g_nobit
                assign w_bit = 1'b0;
            end
            always_comb begin
                w_g = GLYPH_BLANK;
                if (r_disp_bin) begin
                    if (gi < WIDTH)
                        w_g = seg_glyph({3'b000, w_bit});
                end else if (w_ovf) begin
                    w_g = GLYPH_MINUS;
                end else if (gi < w_ndig) begin
                    w_g = seg_glyph(w_nib);
                end else if ((gi == w_ndig) && r_disp_neg) begin
                    w_g = GLYPH_MINUS;
                end
            end
            assign w_glyph_flat[8*gi +: 8] = w_g;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_refresh <= '0;
            r_idx     <= '0;
            r_anode   <= '1;
            r_cathode <= GLYPH_BLANK;
        end else begin
            if (r_refresh == CNTW'(REFRESH - 1)) begin
                r_refresh <= '0;
                r_idx     <= (r_idx == IDXW'(DIGITS - 1)) ? '0 : r_idx + IDXW'(1);
            end else begin
                r_refresh <= r_refresh + CNTW'(1);
            end
            r_anode   <= ~(DIGITS'(1) << r_idx);
            r_cathode <= w_glyph_flat[8*r_idx +: 8];
        end
    end

    assign led     = r_led;
    assign busy    = (r_state == S_CONV);
    assign anode   = r_anode;
    assign cathode = r_cathode;

endmodule

// File: tb/tb_calculator_bcd.sv
// Randomised and directed checks of calculator_bcd against an arithmetic model of the displayed digits.
module tb_calculator_bcd;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] button = 4'd0;
    logic [3:0] switch_x = 4'd0;
    logic [3:0] switch_y = 4'd0;
    logic [7:0] led;
    logic       busy;
    logic [7:0] cathode;
    logic [3:0] anode;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_g [4];

    localparam logic [7:0] G_MINUS = 8'b11111101;
    localparam logic [7:0] G_BLANK = 8'hFF;

    calculator_bcd #(.WIDTH(4), .DIGITS(4), .REFRESH(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .button   (button),
        .switch_x (switch_x),
        .switch_y (switch_y),
        .led      (led),
        .busy     (busy),
        .cathode  (cathode),
        .anode    (anode)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] seg_of(int d);
        case (d)
            0: return 8'b00000011;
            1: return 8'b10011111;
            2: return 8'b00100101;
            3: return 8'b00001101;
            4: return 8'b10011001;
            5: return 8'b01001001;
            6: return 8'b01000001;
            7: return 8'b00011111;
            8: return 8'b00000001;
            9: return 8'b00001001;
            default: return G_BLANK;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_decimal(int r);
        int neg, mag, nd, t, p;
        neg = (r < 0) ? 1 : 0;
        mag = (r < 0) ? -r : r;
        nd = 1;
        t = mag / 10;
        while (t > 0) begin
            nd++;
            t = t / 10;
        end
        p = 1;
        for (int i = 0; i < 4; i++) begin
            if (nd + neg > 4)
                exp_g[i] = G_MINUS;
            else if (i < nd)
                exp_g[i] = seg_of((mag / p) % 10);
            else if (i == nd && neg == 1)
                exp_g[i] = G_MINUS;
            else
                exp_g[i] = G_BLANK;
            p = p * 10;
        end
    endtask

    task automatic model_op(int x, int y, int op);
        int s, r;
        case (op)
            0: model_decimal(x + y);
            1: model_decimal(x - y);
            2: model_decimal(y - x);
            default: begin
                s = y % 4;
                r = ((x >> s) | (x << (4 - s))) & 15;
                for (int i = 0; i < 4; i++)
                    exp_g[i] = seg_of((r >> i) & 1);
            end
        endcase
    endtask

    task automatic check_display(string name);
        logic [7:0] seen [4];
        bit got [4];
        int idx;
        for (int k = 0; k < 4; k++) begin
            got[k] = 1'b0;
            seen[k] = 8'h00;
        end
        repeat (16) begin
            tick();
            case (anode)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            checks++;
            if (idx < 0) begin
                failures++;
                $display("FAIL %s_anode: got %b required one-hot low", name, anode);
            end else begin
                seen[idx] = cathode;
                got[idx] = 1'b1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (!got[k] || seen[k] !== exp_g[k]) begin
                failures++;
                $display("FAIL %s_d%0d: got %b required %b", name, k, seen[k], exp_g[k]);
            end
        end
    endtask

    task automatic do_op(int x, int y, int op, string name);
        int n, bc;
        switch_x = 4'(x);
        switch_y = 4'(y);
        button = 4'b0001 << op;
        n = 0;
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (!busy) begin
            failures++;
            $display("FAIL %s_start: got busy=%b required 1 within 10 cycles", name, busy);
            button = 4'd0;
            return;
        end
        checks++;
        if (led !== {4'(x), 4'(y)}) begin
            failures++;
            $display("FAIL %s_led: got %h required %h", name, led, {4'(x), 4'(y)});
        end
        bc = 0;
        while (busy && bc < 30) begin
            bc++;
            tick();
        end
        checks++;
        if (bc != 5) begin
            failures++;
            $display("FAIL %s_busy_len: got %0d required 5", name, bc);
        end
        button = 4'd0;
        tick();
        tick();
        model_op(x, y, op);
        check_display(name);
        $display("op %s x=%0d y=%0d op=%0d busy_cycles=%0d", name, x, y, op, bc);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (anode !== 4'b1111 || cathode !== 8'hFF) begin
            failures++;
            $display("FAIL reset_pins: got anode=%b cathode=%b required 1111/11111111", anode, cathode);
        end
        checks++;
        if (busy !== 1'b0 || led !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: got busy=%b led=%h required 0/00", busy, led);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (anode !== 4'b1110 || cathode !== 8'b00000011) begin
            failures++;
            $display("FAIL reset_first: got anode=%b cathode=%b required 1110/00000011", anode, cathode);
        end
        model_decimal(0);
        check_display("reset_zero");
        $display("test_reset done");
    endtask

    task automatic test_directed();
        do_op(9, 8, 0, "add_17");
        do_op(3, 15, 1, "sub_neg12");
        do_op(15, 15, 2, "sub_zero");
        do_op(11, 5, 3, "rot_by1");
        do_op(11, 4, 3, "rot_by4");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), "rand");
    endtask

    task automatic test_drop_multi();
        int rises;
        button = 4'b0011;
        rises = 0;
        repeat (12) begin
            tick();
            if (busy) rises++;
        end
        checks++;
        if (rises != 0) begin
            failures++;
            $display("FAIL drop_multi: got %0d busy cycles required 0", rises);
        end
        button = 4'd0;
        repeat (3) tick();
        check_display("drop_keep");
        $display("test_drop_multi busy_cycles=%0d", rises);
    endtask

    task automatic test_busy_ignore();
        int n, rises;
        logic prev;
        switch_x = 4'd5;
        switch_y = 4'd2;
        button = 4'b0001;
        n = 0;
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (!busy) begin
            failures++;
            $display("FAIL busy_ignore_start: got busy=%b required 1", busy);
        end
        button = 4'd0;
        tick();
        switch_x = 4'd1;
        button = 4'b0100;
        rises = 1;
        prev = busy;
        repeat (40) begin
            tick();
            if (busy && !prev) rises++;
            prev = busy;
        end
        checks++;
        if (rises != 1) begin
            failures++;
            $display("FAIL busy_ignore_ops: got %0d required 1", rises);
        end
        button = 4'd0;
        tick();
        tick();
        model_op(5, 2, 0);
        check_display("busy_ignore");
        $display("test_busy_ignore ops=%0d", rises);
    endtask

    task automatic test_hold();
        int rises;
        logic prev;
        switch_x = 4'd6;
        switch_y = 4'd1;
        button = 4'b1000;
        rises = 0;
        prev = busy;
        repeat (100) begin
            tick();
            if (busy && !prev) rises++;
            prev = busy;
        end
        checks++;
        if (rises != 1) begin
            failures++;
            $display("FAIL hold_ops: got %0d required 1", rises);
        end
        button = 4'd0;
        tick();
        tick();
        model_op(6, 1, 3);
        check_display("hold");
        $display("test_hold ops=%0d", rises);
    endtask

    task automatic test_reset_conv();
        int n;
        switch_x = 4'd7;
        switch_y = 4'd7;
        button = 4'b0001;
        n = 0;
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (!busy) begin
            failures++;
            $display("FAIL reset_conv_start: got busy=%b required 1", busy);
        end
        button = 4'd0;
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || led !== 8'h00) begin
            failures++;
            $display("FAIL reset_conv_abort: got busy=%b led=%h required 0/00", busy, led);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (anode !== 4'b1110 || cathode !== 8'b00000011) begin
            failures++;
            $display("FAIL reset_conv_first: got anode=%b cathode=%b required 1110/00000011", anode, cathode);
        end
        model_decimal(0);
        check_display("reset_conv");
        $display("test_reset_conv done");
    endtask

    task automatic test_scan();
        int n;
        logic [3:0] prev, ea;
        n = 0;
        prev = anode;
        tick();
        while (!(anode == 4'b1110 && prev != 4'b1110) && n < 40) begin
            prev = anode;
            tick();
            n++;
        end
        checks++;
        if (anode !== 4'b1110) begin
            failures++;
            $display("FAIL scan_sync: got %b required 1110 within 40 cycles", anode);
            return;
        end
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tick();
            ea = ~(4'b0001 << (k / 4));
            checks++;
            if (anode !== ea) begin
                failures++;
                $display("FAIL scan_order_%0d: got %b required %b", k, anode, ea);
            end
        end
        $display("test_scan done");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_drop_multi();
        test_busy_ignore();
        test_hold();
        test_reset_conv();
        test_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
